// File: rtl/vdic_dut_pkg.sv
// Shared types and constants for the command responder.
// Word length depends on VDIC_RESP_PARITY_EN (adds an even-parity bit per word).
package vdic_dut_pkg;

    typedef enum logic [7:0] {
        CMD_NOP = 8'h00,
        CMD_AND = 8'h01,
        CMD_OR  = 8'h02,
        CMD_XOR = 8'h03,
        CMD_ADD = 8'h10,
        CMD_SUB = 8'h20
    } command_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_STOP,
        ST_CALC,
        ST_TX
    } state_t;

    localparam int STAT_ERR_DATA   = 0;
    localparam int STAT_ERR_CMD    = 1;
    localparam int STAT_ERR_PARITY = 2;

`ifdef VDIC_RESP_PARITY_EN
    localparam int WORD_BITS = 12;
`else
    localparam int WORD_BITS = 11;
`endif

endpackage

// File: rtl/vdic_word_shifter.sv
// Parallel-to-serial shifter for one {flag,byte} response word with start/stop
// framing; VDIC_RESP_PARITY_EN inserts even parity before the stop bit.
module vdic_word_shifter
    import vdic_dut_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [8:0] word_i,
    output logic       dout_o,
    output logic       last_o
);

    localparam int SH_BITS = WORD_BITS - 1;

    logic [SH_BITS-1:0] frame;
    logic [SH_BITS-1:0] shreg_q;
    logic [3:0]         cnt_q;
    logic               active_q;
    logic               dout_q;

`ifdef VDIC_RESP_PARITY_EN
    assign frame = {word_i, ^word_i, 1'b1};
`else
    assign frame = {word_i, 1'b1};
`endif

    // The start bit goes out on the load edge; cnt_q counts the bits still queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= 1'b1;
            shreg_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            dout_q   <= 1'b0;
            shreg_q  <= frame;
            cnt_q    <= 4'(SH_BITS);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q != 4'd0) begin
                dout_q  <= shreg_q[SH_BITS-1];
                shreg_q <= shreg_q << 1;
                cnt_q   <= cnt_q - 4'd1;
            end else begin
                active_q <= 1'b0;
                dout_q   <= 1'b1;
            end
        end
    end

    assign dout_o = dout_q;
    assign last_o = active_q && (cnt_q == 4'd0);

endmodule

// File: rtl/vdic_cmd_responder.sv
// Serial command-packet responder: receives data words, reduces them per opcode,
// and returns {result_hi, result_lo, status}. Parity option: VDIC_RESP_PARITY_EN.
module vdic_cmd_responder
    import vdic_dut_pkg::*;
#(
    parameter int MIN_WORDS = 2,
    parameter int MAX_WORDS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_n,
    input  logic din,
    output logic dout,
    output logic busy
);

    localparam int RX_BITS = WORD_BITS - 2;
    localparam int CW      = $clog2(MAX_WORDS + 2);
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_WORDS);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_WORDS);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_WORDS + 1);

    state_t              state_q;
    logic [3:0]          bit_cnt_q;
    logic [RX_BITS-1:0]  rx_q;
    logic                armed_q;
    logic                busy_q;
    logic [15:0]         result_q;
    logic [7:0]          status_q;
    logic                load_first_q;
    logic [1:0]          word_idx_q;

    logic [CW-1:0]       cnt_q;
    logic [15:0]         add_q, sub_q;
    logic [7:0]          and_q, or_q, xor_q;
    logic                perr_q;

    logic                rx_flag, rx_perr;
    logic [7:0]          rx_byte;
    logic                stop_ok, acc_clr, tx_last, tx_load;
    logic [1:0]          tx_sel;
    logic [8:0]          tx_word;
    logic [15:0]         result_d;
    logic [7:0]          status_d;

    assign rx_flag = rx_q[RX_BITS-1];
    assign rx_byte = rx_q[RX_BITS-2 -: 8];
`ifdef VDIC_RESP_PARITY_EN
    assign rx_perr = rx_q[0] ^ (^{rx_flag, rx_byte});
`else
    assign rx_perr = 1'b0;
`endif

    always_comb begin
        stop_ok = (state_q == ST_STOP) && !enable_n && din;
        acc_clr = ((state_q == ST_RX || state_q == ST_STOP) && enable_n)
               || ((state_q == ST_STOP) && !enable_n && !din)
               || ((state_q == ST_CALC) && (rx_byte == CMD_NOP))
               || ((state_q == ST_TX) && tx_last && (word_idx_q == 2'd2));
    end

    // Per-word reduction; words past MAX_WORDS are only counted.
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            cnt_q  <= '0;
            add_q  <= '0;
            sub_q  <= '0;
            and_q  <= '0;
            or_q   <= '0;
            xor_q  <= '0;
            perr_q <= 1'b0;
        end else if (stop_ok) begin
            perr_q <= perr_q | rx_perr;
            if (!rx_flag) begin
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
                if (cnt_q < MAX_C) begin
                    add_q <= add_q + {8'h00, rx_byte};
                    sub_q <= (cnt_q == '0) ? {8'h00, rx_byte} : sub_q - {8'h00, rx_byte};
                    and_q <= (cnt_q == '0) ? rx_byte : (and_q & rx_byte);
                    or_q  <= or_q  | rx_byte;
                    xor_q <= xor_q ^ rx_byte;
                end
            end
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        result_d = 16'h0000;
        status_d = 8'h00;
        status_d[STAT_ERR_DATA]   = (cnt_q < MIN_C) || (cnt_q > MAX_C);
        status_d[STAT_ERR_PARITY] = perr_q;
        case (rx_byte)
            CMD_NOP: result_d = 16'h0000;
            CMD_AND: result_d = {8'h00, and_q};
            CMD_OR:  result_d = {8'h00, or_q};
            CMD_XOR: result_d = {8'h00, xor_q};
            CMD_ADD: result_d = add_q;
            CMD_SUB: result_d = sub_q;
            default: status_d[STAT_ERR_CMD] = 1'b1;
        endcase
        if (status_d != 8'h00) result_d = 16'h0000;
    end

    always_comb begin
        tx_load = load_first_q || ((state_q == ST_TX) && tx_last && (word_idx_q != 2'd2));
        tx_sel  = load_first_q ? 2'd0 : word_idx_q + 2'd1;
        case (tx_sel)
            2'd0:    tx_word = {1'b0, result_q[15:8]};
            2'd1:    tx_word = {1'b0, result_q[7:0]};
            default: tx_word = {1'b1, status_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            status_q     <= '0;
            load_first_q <= 1'b0;
            word_idx_q   <= '0;
        end else begin
            load_first_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (din) armed_q <= 1'b1;
                    if (armed_q && !enable_n && !din) begin
                        state_q   <= ST_RX;
                        bit_cnt_q <= '0;
                    end
                end
                ST_RX: begin
                    if (enable_n) begin
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        rx_q <= {rx_q[RX_BITS-2:0], din};
                        if (bit_cnt_q == 4'(RX_BITS - 1)) state_q <= ST_STOP;
                        else bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    // A low stop bit or a dropped enable loses the whole packet.
                    if (enable_n || !din) begin
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!rx_flag) begin
                        state_q <= ST_IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (rx_byte == CMD_NOP) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        result_q     <= result_d;
                        status_q     <= status_d;
                        load_first_q <= 1'b1;
                        word_idx_q   <= 2'd0;
                        state_q      <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (tx_last) begin
                        if (word_idx_q == 2'd2) begin
                            busy_q  <= 1'b0;
                            armed_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            word_idx_q <= word_idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    vdic_word_shifter u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load_i (tx_load),
        .word_i (tx_word),
        .dout_o (dout),
        .last_o (tx_last)
    );

    assign busy = busy_q;

endmodule
